// File: rtl/imm_gen_pipe.sv
// RV32I immediate generator with a two-entry (output + skid) elastic buffer.
// Decodes at the input; only the extended immediate and its error flag are stored.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter bit REG_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immext,
    output logic            imm_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam bit BYPASS = !REG_OUT;

    state_t            state_q, state_d;
    logic              ready_q;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic              out_err_q, out_err_d;
    logic [XLEN-1:0]   skid_data_q, skid_data_d;
    logic              skid_err_q, skid_err_d;

    logic [31:0]       imm32;
    logic              dec_err;
    logic [XLEN-1:0]   dec_data;
    logic              accept;
    logic              drain;
    logic              byp_valid;
    logic              unused_instr_bits;

    assign unused_instr_bits = ^instr[6:0];

    // Every format is built as a 32-bit signed value; zero-extended formats
    // have bit 31 clear, so a single sign extension covers all of them.
    always_comb begin
        imm32   = 32'd0;
        dec_err = 1'b0;
        case (immsrc)
            3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            3'b011:  imm32 = {instr[31:12], 12'd0};
            3'b100:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            3'b101:  imm32 = (XLEN == 64) ? {26'd0, instr[25:20]}
                                          : {27'd0, instr[24:20]};
            3'b110:  imm32 = {27'd0, instr[19:15]};
            default: begin
                imm32   = 32'd0;
                dec_err = 1'b1;
            end
        endcase
    end

    if (XLEN > 32) begin : g_sext
        assign dec_data = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_nosext
        assign dec_data = imm32;
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
        end
    end

    // Next-state logic; flush overrides every transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept && !(BYPASS && drain)) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !drain)      state_d = ST_FULL;
                else if (!accept && drain) state_d = ST_EMPTY;
            end
            ST_FULL:  if (drain) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush) state_d = ST_EMPTY;
    end

    // Output logic; in_ready depends on registered state only
    always_comb begin
        in_ready  = ready_q && (state_q != ST_FULL);
        byp_valid = BYPASS && (state_q == ST_EMPTY) && in_valid && in_ready && !flush;
        out_valid = (state_q != ST_EMPTY) || byp_valid;
        immext    = out_data_q;
        imm_err   = out_err_q;
        if (byp_valid) begin
            immext  = dec_data;
            imm_err = dec_err;
        end
    end

    // Buffer datapath: the skid entry moves forward on the same edge as a drain
    always_comb begin
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    out_data_d = dec_data;
                    out_err_d  = dec_err;
                end
                ST_ONE: if (accept) begin
                    if (drain) begin
                        out_data_d = dec_data;
                        out_err_d  = dec_err;
                    end else begin
                        skid_data_d = dec_data;
                        skid_err_d  = dec_err;
                    end
                end
                ST_FULL: if (drain) begin
                    out_data_d = skid_data_q;
                    out_err_d  = skid_err_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances fed the same stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, flush, out_ready;
    logic [31:0] instr;
    logic [2:0]  immsrc;
    logic        in_ready, out_valid, imm_err;
    logic [31:0] immext;
    logic        in_ready64, out_valid64, imm_err64;
    logic [63:0] immext64;

    int total = 0;
    int bad   = 0;

    imm_gen_pipe #(.XLEN(32), .REG_OUT(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .immsrc(immsrc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .immext(immext), .imm_err(imm_err)
    );

    imm_gen_pipe #(.XLEN(64), .REG_OUT(1'b1)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immsrc(immsrc), .flush(flush), .out_valid(out_valid64),
        .out_ready(out_ready), .immext(immext64), .imm_err(imm_err64)
    );

    localparam int NV = 13;
    logic [31:0] v_instr [NV] = '{32'h7FF00000, 32'hFFF00000, 32'h7FFFF000, 32'hFE000F80,
                                  32'h80000000, 32'h80000000, 32'h01F00000, 32'h000F8000,
                                  32'hFFFFFFFF, 32'h00100000, 32'h00000080, 32'hFFFFF000,
                                  32'h03F00000};
    logic [2:0]  v_src   [NV] = '{3'b000, 3'b000, 3'b011, 3'b001, 3'b010, 3'b100, 3'b101,
                                  3'b110, 3'b111, 3'b000, 3'b001, 3'b011, 3'b101};
    logic [31:0] v_e32   [NV] = '{32'h000007FF, 32'hFFFFFFFF, 32'h7FFFF000, 32'hFFFFFFFF,
                                  32'hFFFFF000, 32'hFFF00000, 32'h0000001F, 32'h0000001F,
                                  32'h00000000, 32'h00000001, 32'h00000001, 32'hFFFFF000,
                                  32'h0000001F};
    logic [63:0] v_e64   [NV] = '{64'h7FF, 64'hFFFFFFFFFFFFFFFF, 64'h7FFFF000,
                                  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFF000,
                                  64'hFFFFFFFFFFF00000, 64'h1F, 64'h1F, 64'h0, 64'h1, 64'h1,
                                  64'hFFFFFFFFFFFFF000, 64'h3F};
    logic        v_err   [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                  1'b0, 1'b0, 1'b0, 1'b0};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = 32'd0; immsrc = 3'd0;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        total++; if (immext !== 32'd0) begin bad++; $display("FAIL reset immext: got %h want 0", immext); end
        total++; if (imm_err !== 1'b0) begin bad++; $display("FAIL reset imm_err: got %b want 0", imm_err); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        step; step;
        reset = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release in_ready before edge: got %b want 0", in_ready); end
        step;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release in_ready after edge: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_decode;
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            instr = v_instr[i]; immsrc = v_src[i]; in_valid = 1'b1;
            if (i == 0) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL decode latency: out_valid got %b want 0 in accept cycle", out_valid); end
            end
            step;
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL decode[%0d] out_valid: got %b want 1", i, out_valid); end
            total++; if (immext !== v_e32[i]) begin bad++; $display("FAIL decode[%0d] immext32: got %h want %h", i, immext, v_e32[i]); end
            total++; if (imm_err !== v_err[i]) begin bad++; $display("FAIL decode[%0d] imm_err: got %b want %b", i, imm_err, v_err[i]); end
            total++; if (immext64 !== v_e64[i]) begin bad++; $display("FAIL decode[%0d] immext64: got %h want %h", i, immext64, v_e64[i]); end
            total++; if (imm_err64 !== v_err[i]) begin bad++; $display("FAIL decode[%0d] imm_err64: got %b want %b", i, imm_err64, v_err[i]); end
            step;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL decode[%0d] drained out_valid: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1; immsrc = 3'b000;
        for (int i = 0; i < 5; i++) begin
            instr = 32'(i + 1) << 20; in_valid = 1'b1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b[%0d] in_ready: got %b want 1", i, in_ready); end
            step;
            total++; if (out_valid !== 1'b1 || immext !== 32'(i + 1)) begin
                bad++; $display("FAIL b2b[%0d] output: got valid=%b immext=%h want valid=1 immext=%h", i, out_valid, immext, 32'(i + 1));
            end
        end
        in_valid = 1'b0;
        step;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b tail out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic [31:0] got [8];
        int          n;
        logic        c_taken;
        out_ready = 1'b0; immsrc = 3'b000;
        instr = 32'h00100000; in_valid = 1'b1; step;
        instr = 32'h00200000; step;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp in_ready after B: got %b want 0", in_ready); end
        instr = 32'h00300000;
        step; step;
        total++; if (immext !== 32'd1 || out_valid !== 1'b1) begin bad++; $display("FAIL bp hold: got valid=%b immext=%h want valid=1 immext=1", out_valid, immext); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp C held in_ready: got %b want 0", in_ready); end
        out_ready = 1'b1; n = 0; c_taken = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (out_valid === 1'b1 && n < 8) begin got[n] = immext; n++; end
            if (in_valid && in_ready) c_taken = 1'b1;
            step;
            if (c_taken) in_valid = 1'b0;
        end
        total++; if (n != 3) begin bad++; $display("FAIL bp count: got %0d entries want 3", n); end
        for (int k = 0; k < 3; k++) begin
            total++; if (n > k && got[k] !== 32'(k + 1)) begin bad++; $display("FAIL bp order[%0d]: got %h want %h", k, got[k], 32'(k + 1)); end
        end
    endtask

    task automatic test_flush;
        int leaks;
        out_ready = 1'b0; immsrc = 3'b000;
        instr = 32'h00500000; in_valid = 1'b1; step;
        instr = 32'h00600000; step;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush setup FULL in_ready: got %b want 0", in_ready); end
        instr = 32'h00700000; flush = 1'b1; step;
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush FULL out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush FULL in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1; leaks = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            if (out_valid !== 1'b0) leaks++;
            step;
        end
        total++; if (leaks != 0) begin bad++; $display("FAIL flush leak: got %0d valid cycles want 0", leaks); end
        out_ready = 1'b0;
        instr = 32'h00800000; in_valid = 1'b1; step;
        instr = 32'h00900000; flush = 1'b1; step;
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush ONE out_valid: got %b want 0", out_valid); end
        out_ready = 1'b1; instr = 32'h00A00000; in_valid = 1'b1; step;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || immext !== 32'd10) begin bad++; $display("FAIL flush resume: got valid=%b immext=%h want valid=1 immext=a", out_valid, immext); end
        step;
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0; immsrc = 3'b000;
        instr = 32'h00B00000; in_valid = 1'b1; step;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || immext !== 32'd11) begin bad++; $display("FAIL areset setup: got valid=%b immext=%h want valid=1 immext=b", out_valid, immext); end
        #2; reset = 1'b1; #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset out_valid: got %b want 0", out_valid); end
        total++; if (immext !== 32'd0 || immext64 !== 64'd0) begin bad++; $display("FAIL areset immext: got %h/%h want 0", immext, immext64); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL areset in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        step;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL areset release: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid); end
        instr = 32'h00C00000; in_valid = 1'b1; step;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || immext !== 32'd12) begin bad++; $display("FAIL areset first entry: got valid=%b immext=%h want valid=1 immext=c", out_valid, immext); end
        step;
    endtask

    initial begin
        test_reset;
        test_decode;
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
